// File: rtl/mem_access_unit.sv
// M-stage data-memory access engine: alignment checks, store lane steering,
// a req/ack handshake with a multi-cycle memory and the W-stage load register.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_flush,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [2:0]  m_slctrl,
  input  logic [2:0]  m_sctrl,
  output logic        stall,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        w_valid,
  output logic [31:0] w_memD,
  output logic [1:0]  w_bytesel,
  output logic [2:0]  w_slctrl
);

  localparam logic [2:0] SL_NONE  = 3'd0;
  localparam logic [2:0] SL_WORD  = 3'd1;
  localparam logic [2:0] SL_HALF  = 3'd2;
  localparam logic [2:0] SL_HALFU = 3'd4;

  localparam logic [2:0] ST_NONE = 3'd0;
  localparam logic [2:0] ST_SW   = 3'd1;
  localparam logic [2:0] ST_SH   = 3'd2;
  localparam logic [2:0] ST_SB   = 3'd3;
  localparam logic [2:0] ST_SWL  = 3'd4;
  localparam logic [2:0] ST_SWR  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t state_q, state_d;

  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic             bus_err_q, bus_err_d;
  logic [2:0]       req_slctrl_q, req_slctrl_d;
  logic [1:0]       req_bytesel_q, req_bytesel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             w_valid_q, w_valid_d;
  logic [31:0]      w_memd_q, w_memd_d;
  logic [1:0]       w_bytesel_q, w_bytesel_d;
  logic [2:0]       w_slctrl_q, w_slctrl_d;

  logic [1:0]  a;
  logic        is_load, is_store, op;
  logic        mis_load, mis_store, legal_op, launch;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  assign a = m_addr[1:0];

  always_comb begin
    is_load   = (m_slctrl != SL_NONE);
    is_store  = (m_sctrl != ST_NONE);
    op        = m_valid & ~m_flush & (is_load | is_store);
    mis_load  = 1'b0;
    mis_store = 1'b0;
    case (m_slctrl)
      SL_WORD:           mis_load = (a != 2'b00);
      SL_HALF, SL_HALFU: mis_load = a[0];
      default:           mis_load = 1'b0;
    endcase
    case (m_sctrl)
      ST_SW:   mis_store = (a != 2'b00);
      ST_SH:   mis_store = a[0];
      default: mis_store = 1'b0;
    endcase
    legal_op = op & ~mis_load & ~mis_store;
  end

  // Steer the store bytes onto the lanes they occupy within the aligned word.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0;
    case (m_sctrl)
      ST_SW: begin
        st_be    = 4'b1111;
        st_wdata = m_wdata;
      end
      ST_SH: begin
        st_be    = a[1] ? 4'b1100 : 4'b0011;
        st_wdata = m_wdata << {a[1], 4'b0000};
      end
      ST_SB: begin
        st_be    = 4'b0001 << a;
        st_wdata = m_wdata << {a, 3'b000};
      end
      ST_SWL: begin
        case (a)
          2'd0:    st_be = 4'b0001;
          2'd1:    st_be = 4'b0011;
          2'd2:    st_be = 4'b0111;
          default: st_be = 4'b1111;
        endcase
        st_wdata = m_wdata >> {~a, 3'b000};
      end
      ST_SWR: begin
        st_be    = 4'b1111 << a;
        st_wdata = m_wdata << {a, 3'b000};
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = 32'h0;
      end
    endcase
  end

  // done_q marks the cycle after completion, when the finished instruction
  // is still in M and must not relaunch while the pipeline advances.
  assign launch = (state_q == S_IDLE) & legal_op & ~done_q;

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    bus_err_d     = 1'b0;
    req_slctrl_d  = req_slctrl_q;
    req_bytesel_d = req_bytesel_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    w_valid_d     = 1'b0;
    w_memd_d      = w_memd_q;
    w_bytesel_d   = w_bytesel_q;
    w_slctrl_d    = w_slctrl_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d       = S_BUSY;
          bus_req_d     = 1'b1;
          bus_we_d      = is_store;
          bus_addr_d    = {m_addr[31:2], 2'b00};
          bus_be_d      = is_store ? st_be : 4'b1111;
          bus_wdata_d   = is_store ? st_wdata : 32'h0;
          req_slctrl_d  = m_slctrl;
          req_bytesel_d = a;
          cnt_d         = '0;
        end
      end
      S_BUSY: begin
        if (bus_ack) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (!bus_we_q) begin
            w_valid_d   = 1'b1;
            w_memd_d    = bus_rdata;
            w_bytesel_d = req_bytesel_q;
            w_slctrl_d  = req_slctrl_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_be_q      <= 4'b0000;
      bus_wdata_q   <= 32'h0;
      bus_err_q     <= 1'b0;
      req_slctrl_q  <= SL_NONE;
      req_bytesel_q <= 2'b00;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      w_valid_q     <= 1'b0;
      w_memd_q      <= 32'h0;
      w_bytesel_q   <= 2'b00;
      w_slctrl_q    <= SL_NONE;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_err_q     <= bus_err_d;
      req_slctrl_q  <= req_slctrl_d;
      req_bytesel_q <= req_bytesel_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      w_valid_q     <= w_valid_d;
      w_memd_q      <= w_memd_d;
      w_bytesel_q   <= w_bytesel_d;
      w_slctrl_q    <= w_slctrl_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign stall     = reset & ((state_q == S_BUSY) | launch);
  assign exc_adel  = reset & op & mis_load;
  assign exc_ades  = reset & op & mis_store;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;
  assign w_valid   = w_valid_q;
  assign w_memD    = w_memd_q;
  assign w_bytesel = w_bytesel_q;
  assign w_slctrl  = w_slctrl_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized accesses checked
// against a byte-lane model of what each load/store should put on the bus.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  localparam logic [2:0] SL_NONE = 3'd0, SL_WORD = 3'd1, SL_HALF = 3'd2, SL_BYTE = 3'd3;
  localparam logic [2:0] SL_HALFU = 3'd4, SL_BYTEU = 3'd5, SL_WL = 3'd6, SL_WR = 3'd7;
  localparam logic [2:0] ST_SW = 3'd1, ST_SH = 3'd2, ST_SB = 3'd3, ST_SWL = 3'd4, ST_SWR = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_flush;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_slctrl, m_sctrl;
  logic        stall, exc_adel, exc_ades;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err, w_valid;
  logic [31:0] w_memD;
  logic [1:0]  w_bytesel;
  logic [2:0]  w_slctrl;

  int checks = 0;
  int fails  = 0;

  logic [31:0] lastAddr, lastWdata, lastWmem;
  logic [3:0]  lastBe;

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_flush(m_flush), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_slctrl(m_slctrl), .m_sctrl(m_sctrl),
    .stall(stall), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .w_valid(w_valid), .w_memD(w_memD), .w_bytesel(w_bytesel), .w_slctrl(w_slctrl)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck run still reports and ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Required alignment of an access, in bytes.
  function automatic int accessAlign(input logic [2:0] sl, input logic [2:0] sc);
    if (sl == SL_WORD || sc == ST_SW) return 4;
    if (sl == SL_HALF || sl == SL_HALFU || sc == ST_SH) return 2;
    return 1;
  endfunction

  // Which memory lanes a store writes and which rt byte lands in each lane.
  function automatic void modelStore(input logic [2:0] sc, input logic [1:0] a,
                                     input logic [31:0] rt, output logic [3:0] be,
                                     output logic [31:0] data);
    int lo, hi, src0;
    be = 4'b0000;
    data = 32'h0;
    case (sc)
      ST_SW:   begin lo = 0;      hi = 3;          src0 = 0;         end
      ST_SH:   begin lo = int'(a); hi = int'(a) + 1; src0 = 0;       end
      ST_SB:   begin lo = int'(a); hi = int'(a);     src0 = 0;       end
      ST_SWL:  begin lo = 0;      hi = int'(a);    src0 = 3 - int'(a); end
      ST_SWR:  begin lo = int'(a); hi = 3;         src0 = 0;         end
      default: begin lo = 1;      hi = 0;          src0 = 0;         end
    endcase
    for (int i = lo; i <= hi; i++) begin
      be[i] = 1'b1;
      data[8*i +: 8] = rt[8*(src0 + i - lo) +: 8];
    end
  endfunction

  // One complete M-stage access; ackAfter = bus cycle carrying the ack, 0 = never.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] rt,
                               input logic [2:0] sl, input logic [2:0] sc,
                               input int ackAfter, input logic [31:0] rdata);
    logic [3:0]  eBe;
    logic [31:0] eData, mask;
    bit isLoad, mis, acked, released, first;
    int reqCycles, stallCycles, errSeen, wvSeen, unstable, expReq;
    isLoad = (sl != SL_NONE);
    mis = (int'(addr[1:0]) % accessAlign(sl, sc)) != 0;
    if (isLoad) begin
      eBe = 4'b1111;
      eData = 32'h0;
    end else begin
      modelStore(sc, addr[1:0], rt, eBe, eData);
    end
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{eBe[i]}};

    @(posedge clk); #1;
    m_valid = 1'b1; m_flush = 1'b0; m_addr = addr; m_wdata = rt;
    m_slctrl = sl; m_sctrl = sc; bus_ack = 1'b0;
    #1;
    checkOutput("exc_adel", 32'(exc_adel), 32'(isLoad && mis));
    checkOutput("exc_ades", 32'(exc_ades), 32'(!isLoad && mis));
    checkOutput("launch stall", 32'(stall), 32'(!mis));
    if (mis) begin
      @(posedge clk); #1;
      m_valid = 1'b0;
      #1;
      checkOutput("misaligned no req", 32'(bus_req), 32'd0);
      return;
    end

    reqCycles = 0; stallCycles = 1; errSeen = 0; wvSeen = 0; unstable = 0;
    released = 1'b0; first = 1'b1;
    for (int n = 1; n <= TIMEOUT + 3; n++) begin
      @(posedge clk); #1;
      if (released) m_valid = 1'b0;
      bus_ack = (n == ackAfter);
      bus_rdata = (n == ackAfter) ? rdata : $urandom;
      m_flush = 1'($urandom_range(0, 1));
      #1;
      if (bus_req) begin
        reqCycles++;
        if (first) begin
          lastAddr = bus_addr; lastBe = bus_be; lastWdata = bus_wdata;
          checkOutput("bus_addr", bus_addr, {addr[31:2], 2'b00});
          checkOutput("bus_be", 32'(bus_be), 32'(eBe));
          checkOutput("bus_we", 32'(bus_we), 32'(!isLoad));
          if (!isLoad) checkOutput("bus_wdata lanes", bus_wdata & mask, eData);
          first = 1'b0;
        end else if (bus_addr !== lastAddr || bus_be !== lastBe || bus_wdata !== lastWdata) begin
          unstable++;
        end
      end
      if (stall) stallCycles++;
      else released = 1'b1;
      if (bus_err) errSeen++;
      if (w_valid) begin
        wvSeen++;
        lastWmem = w_memD;
        checkOutput("w_memD", w_memD, rdata);
        checkOutput("w_bytesel", 32'(w_bytesel), 32'(addr[1:0]));
        checkOutput("w_slctrl", 32'(w_slctrl), 32'(sl));
      end
    end
    m_valid = 1'b0; m_flush = 1'b0; bus_ack = 1'b0;

    acked = (ackAfter >= 1 && ackAfter <= TIMEOUT);
    expReq = acked ? ackAfter : TIMEOUT;
    checkOutput("req cycles", reqCycles, expReq);
    checkOutput("stall cycles", stallCycles, expReq + 1);
    checkOutput("bus_err pulses", errSeen, acked ? 0 : 1);
    checkOutput("w_valid pulses", wvSeen, (acked && isLoad) ? 1 : 0);
    checkOutput("bus held stable", unstable, 0);
  endtask

  initial begin
    reset = 1'b0; m_valid = 1'b0; m_flush = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    m_slctrl = SL_NONE; m_sctrl = 3'd0; bus_ack = 1'b0; bus_rdata = 32'h0;
    lastAddr = 32'h0; lastWdata = 32'h0; lastWmem = 32'h0; lastBe = 4'h0;
    #3;
    checkOutput("reset bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset w_valid", 32'(w_valid), 32'd0);
    checkOutput("reset w_slctrl", 32'(w_slctrl), 32'(SL_NONE));
    checkOutput("reset bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    $display("[TB] directed stores");
    applyStimulus(32'h100, 32'h11223344, SL_NONE, ST_SW, 3, 32'h0);
    checkOutput("sw addr", lastAddr, 32'h100);
    checkOutput("sw be", 32'(lastBe), 32'hF);
    checkOutput("sw wdata", lastWdata, 32'h11223344);
    applyStimulus(32'h203, 32'h000000AB, SL_NONE, ST_SB, 1, 32'h0);
    checkOutput("sb addr", lastAddr, 32'h200);
    checkOutput("sb be", 32'(lastBe), 32'h8);
    checkOutput("sb wdata", lastWdata, 32'hAB000000);
    applyStimulus(32'h201, 32'hAABBCCDD, SL_NONE, ST_SWL, 2, 32'h0);
    checkOutput("swl be", 32'(lastBe), 32'h3);
    checkOutput("swl wdata", lastWdata, 32'h0000AABB);
    applyStimulus(32'h201, 32'hAABBCCDD, SL_NONE, ST_SWR, 1, 32'h0);
    checkOutput("swr be", 32'(lastBe), 32'hE);
    checkOutput("swr wdata", lastWdata, 32'hBBCCDD00);

    $display("[TB] directed loads, misalignment and timeout");
    applyStimulus(32'h102, 32'h0, SL_HALF, 3'd0, 2, 32'h87654321);
    checkOutput("lh w_memD", lastWmem, 32'h87654321);
    applyStimulus(32'h101, 32'h0, SL_WORD, 3'd0, 1, 32'h0);
    applyStimulus(32'h103, 32'h1234, SL_NONE, ST_SH, 1, 32'h0);
    applyStimulus(32'h80, 32'h0, SL_WORD, 3'd0, 0, 32'h0);

    $display("[TB] flush blocks launch");
    @(posedge clk); #1;
    m_valid = 1'b1; m_flush = 1'b1; m_addr = 32'h101; m_slctrl = SL_WORD; m_sctrl = 3'd0;
    #1;
    checkOutput("flush no adel", 32'(exc_adel), 32'd0);
    checkOutput("flush no stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    m_addr = 32'h104;
    #1;
    checkOutput("flush no req", 32'(bus_req), 32'd0);
    checkOutput("flush aligned no stall", 32'(stall), 32'd0);
    m_valid = 1'b0; m_flush = 1'b0;

    $display("[TB] reset mid-transaction");
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = 32'h300; m_slctrl = SL_WORD; m_sctrl = 3'd0; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checkOutput("busy before reset", 32'(bus_req), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("reset drops bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset drops stall", 32'(stall), 32'd0);
    checkOutput("reset w_valid low", 32'(w_valid), 32'd0);
    m_valid = 1'b0; bus_ack = 1'b1; bus_rdata = $urandom;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #2;
    checkOutput("idle ack no req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
    @(posedge clk); #2;
    checkOutput("idle ack ignored", 32'(w_valid), 32'd0);
    applyStimulus(32'h300, 32'h0, SL_WORD, 3'd0, 2, 32'hCAFEF00D);

    $display("[TB] randomized accesses");
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra, rt, rd;
      logic [2:0] sl, sc;
      int ack;
      ra = $urandom; rt = $urandom; rd = $urandom;
      ack = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 0) begin
        sl = 3'($urandom_range(1, 7)); sc = 3'd0;
      end else begin
        sl = SL_NONE; sc = 3'($urandom_range(1, 5));
      end
      applyStimulus(ra, rt, sl, sc, ack, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
